// File: rtl/kanagawa_sdpram_pkg.sv
// Shared constants and the RAM-style attribute selection for kanagawa_simple_dual_port_ram.
package kanagawa_sdpram_pkg;

  localparam int MAX_BYPASS_SLOTS = 4;

  localparam string INTEL_LUTRAM_STYLE  = "MLAB";
  localparam string INTEL_BRAM_STYLE    = "M20K";
  localparam string XILINX_LUTRAM_STYLE = "distributed";
  localparam string XILINX_BRAM_STYLE   = "block";
  localparam string STYLE_AUTO          = "";
  localparam string STYLE_INVALID       = "invalid";

  // Intel families spell the attribute ramstyle; everything else uses ram_style values.
  function automatic string ram_style_attr(input string family, input bit use_lutram,
                                           input bit use_bram);
    bit is_intel;
    is_intel = (family == "Stratix10") || (family == "Agilex");
    if (use_lutram && use_bram) return STYLE_INVALID;
    if (use_lutram) return is_intel ? INTEL_LUTRAM_STYLE : XILINX_LUTRAM_STYLE;
    if (use_bram) return is_intel ? INTEL_BRAM_STYLE : XILINX_BRAM_STYLE;
    return STYLE_AUTO;
  endfunction

endpackage

// File: rtl/kanagawa_sdpram_bypass.sv
// Write-forwarding network: shift register of recent writes plus same-cycle write compare.
module kanagawa_sdpram_bypass
  import kanagawa_sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_SLOTS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wren_in,
  input  logic [ADDR_WIDTH-1:0] writeaddr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] readaddr_in,
  output logic                  hit_out,
  output logic [DATA_WIDTH-1:0] hit_data_out
);

  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] data_d [NUM_SLOTS];

  // Slot 0 is the newest write; the register only advances when a write happens.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (wren_in) begin
      valid_d[0] = 1'b1;
      addr_d[0]  = writeaddr_in;
      data_d[0]  = data_in;
      for (int i = 1; i < NUM_SLOTS; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Scan oldest to newest so a newer match overrides; the same-cycle write overrides all.
  always_comb begin
    hit_out      = 1'b0;
    hit_data_out = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == readaddr_in)) begin
        hit_out      = 1'b1;
        hit_data_out = data_q[i];
      end
    end
    if (wren_in && (writeaddr_in == readaddr_in)) begin
      hit_out      = 1'b1;
      hit_data_out = data_in;
    end
  end

endmodule

// File: rtl/kanagawa_simple_dual_port_ram.sv
// Single-clock simple dual-port RAM with optional write bypass and output register.
// Define KANAGAWA_SDPRAM_ZERO_INIT_EN to zero-initialise the array at time 0.
module kanagawa_simple_dual_port_ram
  import kanagawa_sdpram_pkg::*;
#(
  parameter int    DATA_WIDTH       = 32,
  parameter int    ADDR_WIDTH       = 10,
  parameter int    USE_LUTRAM       = 0,
  parameter int    USE_BRAM         = 1,
  parameter int    USE_OUTPUT_REG   = 0,
  parameter int    NUM_BYPASS_SLOTS = 1,
  parameter string DEVICE_FAMILY    = "Stratix10"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rden_in,
  input  logic [ADDR_WIDTH-1:0] readaddr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wren_in,
  input  logic [ADDR_WIDTH-1:0] writeaddr_in,
  input  logic [DATA_WIDTH-1:0] data_in
);

  localparam int    DEPTH     = 1 << ADDR_WIDTH;
  localparam string RAM_STYLE = ram_style_attr(DEVICE_FAMILY, USE_LUTRAM != 0, USE_BRAM != 0);

  if (RAM_STYLE == STYLE_INVALID) begin : g_style_err
    $error("USE_LUTRAM and USE_BRAM cannot both be set");
  end
  if (NUM_BYPASS_SLOTS < 0 || NUM_BYPASS_SLOTS > MAX_BYPASS_SLOTS) begin : g_slots_err
    $error("NUM_BYPASS_SLOTS out of range 0..4");
  end

`ifdef KANAGAWA_SDPRAM_ZERO_INIT_EN
  (* ramstyle = RAM_STYLE, ram_style = RAM_STYLE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
`else
  (* ramstyle = RAM_STYLE, ram_style = RAM_STYLE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`endif
  logic [DATA_WIDTH-1:0] mem_rd_q;

  // NOTE: the array and its read register carry no reset so they map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wren_in) mem[writeaddr_in] <= data_in;
    if (rden_in) mem_rd_q <= mem[readaddr_in];
  end

  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  if (NUM_BYPASS_SLOTS > 0) begin : g_bypass
    kanagawa_sdpram_bypass #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLOTS  (NUM_BYPASS_SLOTS)
    ) u_bypass (
      .clk          (clk),
      .rst          (rst),
      .wren_in      (wren_in),
      .writeaddr_in (writeaddr_in),
      .data_in      (data_in),
      .readaddr_in  (readaddr_in),
      .hit_out      (byp_hit),
      .hit_data_out (byp_data)
    );
  end else begin : g_no_bypass
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
  end

  // rd_valid gates the unreset RAM output so data_out reads 0 until the first post-reset read.
  logic                  rd_valid_q, rd_valid_d;
  logic                  byp_hit_q, byp_hit_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    rd_valid_d = rd_valid_q | rden_in;
    byp_hit_d  = rden_in ? byp_hit  : byp_hit_q;
    byp_data_d = rden_in ? byp_data : byp_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rd_data = !rd_valid_q ? '0 : (byp_hit_q ? byp_data_q : mem_rd_q);

  if (USE_OUTPUT_REG != 0) begin : g_out_reg
    logic                  rden_q;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb out_d = rden_q ? rd_data : out_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rden_q <= 1'b0;
        out_q  <= '0;
      end else begin
        rden_q <= rden_in;
        out_q  <= out_d;
      end
    end

    assign data_out = out_q;
  end else begin : g_no_out_reg
    assign data_out = rd_data;
  end

endmodule

// File: tb/tb_kanagawa_simple_dual_port_ram.sv
// Scoreboard bench: three RAM configurations share one stimulus stream and one array model.
module tb_kanagawa_simple_dual_port_ram;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rden_in, wren_in;
  logic [AW-1:0] readaddr_in, writeaddr_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out_a, data_out_b, data_out_c;

  always #5 clk = ~clk;

  // a: defaults (1 slot, no output reg); b: no bypass + output reg; c: 4 slots, LUT RAM.
  kanagawa_simple_dual_port_ram dut_a (
    .clk(clk), .rst(rst), .rden_in(rden_in), .readaddr_in(readaddr_in), .data_out(data_out_a),
    .wren_in(wren_in), .writeaddr_in(writeaddr_in), .data_in(data_in));

  kanagawa_simple_dual_port_ram #(.USE_OUTPUT_REG(1), .NUM_BYPASS_SLOTS(0),
                                  .DEVICE_FAMILY("Agilex")) dut_b (
    .clk(clk), .rst(rst), .rden_in(rden_in), .readaddr_in(readaddr_in), .data_out(data_out_b),
    .wren_in(wren_in), .writeaddr_in(writeaddr_in), .data_in(data_in));

  kanagawa_simple_dual_port_ram #(.NUM_BYPASS_SLOTS(4), .USE_LUTRAM(1), .USE_BRAM(0),
                                  .DEVICE_FAMILY("Artix7")) dut_c (
    .clk(clk), .rst(rst), .rden_in(rden_in), .readaddr_in(readaddr_in), .data_out(data_out_c),
    .wren_in(wren_in), .writeaddr_in(writeaddr_in), .data_in(data_in));

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem_m [1 << AW];
  logic [DW-1:0] q_a [$];
  logic [DW-1:0] q_b [$];
  logic [DW-1:0] q_c [$];
  logic [DW-1:0] hold_a = '0, hold_b = '0, hold_c = '0;
  bit            pend_a = 1'b0, rq_b = 1'b0, load_b = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. Expected read data comes straight from the contract:
  // with bypass, a same-cycle write to the read address is seen; without it, old data.
  task automatic drive(input bit re, input logic [AW-1:0] ra, input bit we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(negedge clk);
    rden_in      = re;
    readaddr_in  = ra;
    wren_in      = we;
    writeaddr_in = wa;
    data_in      = wd;
    if (re) begin
      q_a.push_back((we && wa == ra) ? wd : mem_m[ra]);
      q_c.push_back((we && wa == ra) ? wd : mem_m[ra]);
      q_b.push_back(mem_m[ra]);
    end
    if (we) mem_m[wa] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(0, 7) == 0) ? AW'(1023) : AW'($urandom_range(0, 15));
  endfunction

  // Monitor: tracks when each DUT presents a read result and compares it every cycle,
  // so a held output is checked too.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        pend_a = 1'b0;
        rq_b   = 1'b0;
        load_b = 1'b0;
      end else begin
        pend_a = rden_in;
        load_b = rq_b;
        rq_b   = rden_in;
      end
      #1;
      if (pend_a) begin
        if (q_a.size() == 0 || q_c.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow_ac: read completed with no expected entry");
        end else begin
          hold_a = q_a.pop_front();
          hold_c = q_c.pop_front();
        end
      end
      if (load_b) begin
        if (q_b.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow_b: read completed with no expected entry");
        end else begin
          hold_b = q_b.pop_front();
        end
      end
      check("data_out_a", data_out_a, hold_a);
      check("data_out_b", data_out_b, hold_b);
      check("data_out_c", data_out_c, hold_c);
    end
  end

  initial begin
    rst          = 1'b0;
    rden_in      = 1'b0;
    wren_in      = 1'b0;
    readaddr_in  = '0;
    writeaddr_in = '0;
    data_in      = '0;
`ifdef KANAGAWA_SDPRAM_ZERO_INIT_EN
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
`endif

    repeat (3) @(negedge clk);
    check("reset_a", data_out_a, '0);
    check("reset_b", data_out_b, '0);
    check("reset_c", data_out_c, '0);
    rst = 1'b1;
    idle(2);

`ifdef KANAGAWA_SDPRAM_ZERO_INIT_EN
    drive(1'b1, AW'(1023), 1'b0, '0, '0);
    idle(3);
`endif

    // Write then read the next cycle.
    drive(1'b0, '0, 1'b1, AW'(5), 32'h0000_1234);
    drive(1'b1, AW'(5), 1'b0, '0, '0);
    idle(3);

    // Same-cycle write/read of one address: new data with bypass, old data without.
    drive(1'b0, '0, 1'b1, AW'(7), 32'h0000_5555);
    idle(1);
    drive(1'b1, AW'(7), 1'b1, AW'(7), 32'h0000_AAAA);
    idle(3);

    // Back-to-back writes to addr 3 with an interleaved write to addr 4.
    drive(1'b0, '0, 1'b1, AW'(3), 32'd1);
    drive(1'b0, '0, 1'b1, AW'(3), 32'd2);
    drive(1'b0, '0, 1'b1, AW'(4), 32'd9);
    drive(1'b1, AW'(3), 1'b1, AW'(3), 32'd3);
    drive(1'b1, AW'(3), 1'b0, '0, '0);
    drive(1'b1, AW'(4), 1'b0, '0, '0);
    idle(4);

    // Asynchronous reset right after a read completes, then the array must still hold data.
    drive(1'b1, AW'(5), 1'b0, '0, '0);
    @(negedge clk);
    #2;
    rden_in = 1'b0;
    wren_in = 1'b0;
    rst     = 1'b0;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    hold_a = '0;
    hold_b = '0;
    hold_c = '0;
    #1;
    check("async_reset_a", data_out_a, '0);
    check("async_reset_b", data_out_b, '0);
    check("async_reset_c", data_out_c, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);
    drive(1'b1, AW'(5), 1'b0, '0, '0);
    idle(3);

    // Fill the random address pool, then mixed random traffic.
    for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, AW'(i), $urandom);
    drive(1'b0, '0, 1'b1, AW'(1023), $urandom);
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), pick_addr(), ($urandom_range(0, 1) != 0),
            pick_addr(), $urandom);
    end
    idle(4);

    check("drain_q_a", DW'(q_a.size()), '0);
    check("drain_q_b", DW'(q_b.size()), '0);
    check("drain_q_c", DW'(q_c.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
